mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage of the 64-bit LEGv8 pipeline.
- Holds the EX/MEM pipeline register and resolves the branch.
- Runs a valid/ready handshake with data memory and stalls the pipeline while an access is outstanding.
- Produces the MEM/WB register contents consumed by writeback.

---
 rtl/mem_stage_pkg.sv | 17 +
 rtl/mem_stage_if.sv | 24 ++
 rtl/mem_access_fsm.sv | 59 +++++
 rtl/mem_stage.sv | 121 ++++++++++++
 tb/tb_mem_stage.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the LEGv8 memory stage.
package mem_stage_pkg;

    localparam int unsigned CTRL_W        = 5;
    localparam int unsigned CTRL_BRANCH   = 4;
    localparam int unsigned CTRL_MEMREAD  = 3;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_REGWRITE = 1;
    localparam int unsigned CTRL_MEMTOREG = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response handshake between the memory stage and data memory.
interface mem_stage_if #(
    parameter int unsigned N = 64
) ();

    logic         dm_req_valid;
    logic         dm_req_ready;
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic         dm_we;
    logic         dm_rsp_valid;
    logic [N-1:0] dm_rdata;

    modport master (
        output dm_req_valid, dm_addr, dm_wdata, dm_we,
        input  dm_req_ready, dm_rsp_valid, dm_rdata
    );

    modport slave (
        input  dm_req_valid, dm_addr, dm_wdata, dm_we,
        output dm_req_ready, dm_rsp_valid, dm_rdata
    );

endinterface

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: issues the request, waits for load data,
// and holds the pipeline until the access completes.
module mem_access_fsm
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_en,
    input  logic is_store,
    input  logic req_ready,
    input  logic rsp_valid,
    output logic req_valid,
    output logic stall
);

    state_t state;
    state_t state_nxt;
    logic   done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stores finish on acceptance; loads finish when the response arrives.
    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, REQ: begin
                req_valid = req_en;
                if (!req_en) begin
                    state_nxt = IDLE;
                end else if (!req_ready) begin
                    state_nxt = REQ;
                end else if (is_store) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall = req_en & ~done;

endmodule

// File: rtl/mem_stage.sv
// LEGv8 memory stage: EX/MEM register, branch resolution, data-memory access
// and MEM/WB register. Optional MEM_STAGE_MISALIGN_CHECK_EN blocks unaligned accesses.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned N    = 64,
    parameter int unsigned RD_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_E,
    input  logic [N-1:0]      PCBranch_E,
    input  logic [N-1:0]      aluResult_E,
    input  logic [N-1:0]      writeData_E,
    input  logic              zero_E,
    input  logic [CTRL_W-1:0] ctrl_E,
    input  logic [RD_W-1:0]   rd_E,
    input  logic              flush,
    output logic              stall_M,
    output logic              PCSrc_M,
    output logic [N-1:0]      PCBranch_M,
    mem_stage_if.master       dm,
    output logic              valid_W,
    output logic [N-1:0]      result_W,
    output logic [RD_W-1:0]   rd_W,
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    output logic              misalign_W,
`endif
    output logic              RegWrite_W
);

    logic              valid_m;
    logic              zero_m;
    logic [CTRL_W-1:0] ctrl_m;
    logic [N-1:0]      alu_result_m;
    logic [N-1:0]      write_data_m;
    logic [RD_W-1:0]   rd_m;

    logic memop;
    logic misalign_m;
    logic req_en;
    logic req_valid;
    logic stall;

    assign memop = valid_m & (ctrl_m[CTRL_MEMREAD] | ctrl_m[CTRL_MEMWRITE]);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    assign misalign_m = memop & (alu_result_m[2:0] != 3'b000);
`else
    assign misalign_m = 1'b0;
`endif

    assign req_en = memop & ~misalign_m;

    mem_access_fsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .req_en    (req_en),
        .is_store  (ctrl_m[CTRL_MEMWRITE]),
        .req_ready (dm.dm_req_ready),
        .rsp_valid (dm.dm_rsp_valid),
        .req_valid (req_valid),
        .stall     (stall)
    );

    assign stall_M         = stall;
    assign PCSrc_M         = valid_m & ctrl_m[CTRL_BRANCH] & zero_m;
    assign dm.dm_req_valid = req_valid;
    assign dm.dm_addr      = alu_result_m;
    assign dm.dm_wdata     = write_data_m;
    assign dm.dm_we        = ctrl_m[CTRL_MEMWRITE];

    // EX/MEM register; frozen (flush included) while an access is outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_m      <= 1'b0;
            zero_m       <= 1'b0;
            ctrl_m       <= '0;
            alu_result_m <= '0;
            write_data_m <= '0;
            rd_m         <= '0;
            PCBranch_M   <= '0;
        end else if (!stall) begin
            valid_m      <= valid_E & ~flush;
            zero_m       <= zero_E;
            ctrl_m       <= ctrl_E;
            alu_result_m <= aluResult_E;
            write_data_m <= writeData_E;
            rd_m         <= rd_E;
            PCBranch_M   <= PCBranch_E;
        end
    end

    // MEM/WB register; a stalled cycle sends a bubble downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_W    <= 1'b0;
            result_W   <= '0;
            rd_W       <= '0;
            RegWrite_W <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            misalign_W <= 1'b0;
`endif
        end else if (stall) begin
            valid_W    <= 1'b0;
            RegWrite_W <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            misalign_W <= 1'b0;
`endif
        end else begin
            valid_W    <= valid_m;
            result_W   <= ctrl_m[CTRL_MEMTOREG] ? dm.dm_rdata : alu_result_m;
            rd_W       <= rd_m;
            RegWrite_W <= valid_m & ctrl_m[CTRL_REGWRITE] & ~misalign_m;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            misalign_W <= misalign_m;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU pass-through, load/store handshakes,
// branch resolution, flush and reset during an outstanding load.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int unsigned N    = 64;
    localparam int unsigned RD_W = 5;

    localparam logic [4:0] C_ALU    = 5'b00010;
    localparam logic [4:0] C_LOAD   = 5'b01011;
    localparam logic [4:0] C_STORE  = 5'b00100;
    localparam logic [4:0] C_BRANCH = 5'b10000;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_E;
    logic [N-1:0]      PCBranch_E;
    logic [N-1:0]      aluResult_E;
    logic [N-1:0]      writeData_E;
    logic              zero_E;
    logic [CTRL_W-1:0] ctrl_E;
    logic [RD_W-1:0]   rd_E;
    logic              flush;
    logic              stall_M;
    logic              PCSrc_M;
    logic [N-1:0]      PCBranch_M;
    logic              valid_W;
    logic [N-1:0]      result_W;
    logic [RD_W-1:0]   rd_W;
    logic              RegWrite_W;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    logic              misalign_W;
`endif

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    mem_stage_if #(.N(N)) dm ();

    mem_stage #(.N(N), .RD_W(RD_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_E     (valid_E),
        .PCBranch_E  (PCBranch_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .zero_E      (zero_E),
        .ctrl_E      (ctrl_E),
        .rd_E        (rd_E),
        .flush       (flush),
        .stall_M     (stall_M),
        .PCSrc_M     (PCSrc_M),
        .PCBranch_M  (PCBranch_M),
        .dm          (dm.master),
        .valid_W     (valid_W),
        .result_W    (result_W),
        .rd_W        (rd_W),
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        .misalign_W  (misalign_W),
`endif
        .RegWrite_W  (RegWrite_W)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic v, input logic [4:0] c, input logic [63:0] alu,
                         input logic [63:0] wd, input logic [4:0] rd);
        valid_E     = v;
        ctrl_E      = c;
        aluResult_E = alu;
        writeData_E = wd;
        rd_E        = rd;
    endtask

    initial begin
        reset              = 1'b0;
        set_e(1'b0, 5'b0, 64'h0, 64'h0, 5'd0);
        PCBranch_E         = '0;
        zero_E             = 1'b0;
        flush              = 1'b0;
        dm.dm_req_ready    = 1'b0;
        dm.dm_rsp_valid    = 1'b0;
        dm.dm_rdata        = '0;

        // Reset state
        #3;
        chk("rst_valid_W", valid_W, 0);
        chk("rst_stall", stall_M, 0);
        chk("rst_req_valid", dm.dm_req_valid, 0);
        chk("rst_pcsrc", PCSrc_M, 0);
        chk("rst_regwrite", RegWrite_W, 0);
        chk("rst_result", result_W, 0);
        tick();
        reset = 1'b1;

        // ADD: visible at W two edges later
        set_e(1'b1, C_ALU, 64'h10, 64'h0, 5'd3);
        tick();
        set_e(1'b0, 5'b0, 64'h0, 64'h0, 5'd0);
        #1 chk("add_no_stall", stall_M, 0);
        tick();
        chk("add_valid_W", valid_W, 1);
        chk("add_result", result_W, 64'h10);
        chk("add_rd", rd_W, 3);
        chk("add_regwrite", RegWrite_W, 1);
        chk("add_no_stall2", stall_M, 0);

        // Load 0x20, ready immediately, rsp next cycle
        set_e(1'b1, C_LOAD, 64'h20, 64'h0, 5'd5);
        tick();
        set_e(1'b0, 5'b0, 64'h0, 64'h0, 5'd0);
        dm.dm_req_ready = 1'b1;
        #1;
        chk("ld_req_valid", dm.dm_req_valid, 1);
        chk("ld_addr", dm.dm_addr, 64'h20);
        chk("ld_we", dm.dm_we, 0);
        chk("ld_stall", stall_M, 1);
        tick();
        dm.dm_req_ready = 1'b0;
        dm.dm_rsp_valid = 1'b1;
        dm.dm_rdata     = 64'hDEAD;
        #1;
        chk("ld_wait_req", dm.dm_req_valid, 0);
        chk("ld_stall_end", stall_M, 0);
        chk("ld_bubble", valid_W, 0);
        tick();
        dm.dm_rsp_valid = 1'b0;
        dm.dm_rdata     = '0;
        chk("ld_valid_W", valid_W, 1);
        chk("ld_result", result_W, 64'hDEAD);
        chk("ld_rd", rd_W, 5);
        chk("ld_regwrite", RegWrite_W, 1);

        // Store 0x8, ready low for 3 cycles
        set_e(1'b1, C_STORE, 64'h8, 64'hCAFE, 5'd0);
        tick();
        set_e(1'b0, 5'b0, 64'h0, 64'h0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            dm.dm_req_ready = (i == 3);
            #1;
            chk("st_req_valid", dm.dm_req_valid, 1);
            chk("st_addr", dm.dm_addr, 64'h8);
            chk("st_wdata", dm.dm_wdata, 64'hCAFE);
            chk("st_we", dm.dm_we, 1);
            chk("st_stall", stall_M, (i < 3) ? 64'd1 : 64'd0);
            chk("st_bubble", valid_W, 0);
            tick();
        end
        dm.dm_req_ready = 1'b0;
        chk("st_req_drop", dm.dm_req_valid, 0);
        chk("st_valid_W", valid_W, 1);
        chk("st_regwrite", RegWrite_W, 0);

        // CBZ taken then not taken
        set_e(1'b1, C_BRANCH, 64'h0, 64'h0, 5'd0);
        zero_E     = 1'b1;
        PCBranch_E = 64'h400;
        tick();
        chk("cbz_pcsrc", PCSrc_M, 1);
        chk("cbz_target", PCBranch_M, 64'h400);
        zero_E     = 1'b0;
        PCBranch_E = 64'h800;
        tick();
        chk("cbz_nt_pcsrc", PCSrc_M, 0);
        chk("cbz_nt_target", PCBranch_M, 64'h800);

        // Flushed store never requests
        set_e(1'b1, C_STORE, 64'h10, 64'h55, 5'd0);
        PCBranch_E = '0;
        flush      = 1'b1;
        tick();
        set_e(1'b0, 5'b0, 64'h0, 64'h0, 5'd0);
        flush           = 1'b0;
        dm.dm_req_ready = 1'b1;
        #1;
        chk("fl_req_valid", dm.dm_req_valid, 0);
        chk("fl_stall", stall_M, 0);
        tick();
        dm.dm_req_ready = 1'b0;
        chk("fl_valid_W", valid_W, 0);

        // Reset while waiting for load data
        set_e(1'b1, C_LOAD, 64'h30, 64'h0, 5'd7);
        tick();
        set_e(1'b0, 5'b0, 64'h0, 64'h0, 5'd0);
        dm.dm_req_ready = 1'b1;
        #1 chk("rw_req_valid", dm.dm_req_valid, 1);
        tick();
        dm.dm_req_ready = 1'b0;
        #1;
        chk("rw_wait_req", dm.dm_req_valid, 0);
        chk("rw_wait_stall", stall_M, 1);
        reset = 1'b0;
        #1;
        chk("rw_rst_req", dm.dm_req_valid, 0);
        chk("rw_rst_stall", stall_M, 0);
        chk("rw_rst_valid_W", valid_W, 0);
        reset = 1'b1;
        tick();
        dm.dm_rsp_valid = 1'b1;
        dm.dm_rdata     = 64'hBEEF;
        #1;
        chk("rw_late_stall", stall_M, 0);
        chk("rw_late_req", dm.dm_req_valid, 0);
        set_e(1'b1, C_LOAD, 64'h40, 64'h0, 5'd9);
        tick();
        dm.dm_rsp_valid = 1'b0;
        dm.dm_rdata     = '0;
        set_e(1'b0, 5'b0, 64'h0, 64'h0, 5'd0);
        chk("rw_late_valid_W", valid_W, 0);
        chk("rw_late_result", result_W, 0);
        dm.dm_req_ready = 1'b1;
        #1;
        chk("rw_idle_req", dm.dm_req_valid, 1);
        chk("rw_idle_addr", dm.dm_addr, 64'h40);
        tick();
        dm.dm_req_ready = 1'b0;
        dm.dm_rsp_valid = 1'b1;
        dm.dm_rdata     = 64'h1234;
        #1 chk("rw_ld2_stall", stall_M, 0);
        tick();
        dm.dm_rsp_valid = 1'b0;
        chk("rw_ld2_valid_W", valid_W, 1);
        chk("rw_ld2_result", result_W, 64'h1234);
        chk("rw_ld2_rd", rd_W, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
